ysyx_2022040010_uncache_bridge: RTL and testbench
=================================================

Name: ysyx_2022040010_uncache_bridge

Overview:
- Downstream consumer of the address classifier's uncache flag in the LSU memory path.
- Accepts one uncached (MMIO) load/store request from the core and performs a single-beat AXI4 read or write transaction.
- Returns the byte-lane-aligned result to the core.
- One request in flight at a time; cached requests are ignored and handled by the D-cache.

Parameters:
- ADDR_W, 64, address width of the core request and AXI address channels
- DATA_W, 64, data width of the core request and AXI data channels
- TIMEOUT_CYCLES, 255, watchdog limit; used only with UNCACHE_TIMEOUT_EN

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  bridge can accept a request
- req_uncache  in  1  classifier flag; the request belongs to this bridge only when set
- req_we  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_size  in  3  log2 bytes (0..3)
- req_wdata  in  DATA_W  store data, LSB-aligned
- req_wstrb  in  8  store byte mask, LSB-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  DATA_W  load data shifted right by addr[2:0] bytes
- resp_err  out  1  AXI resp != OKAY (or timeout)
- axi_ar_valid, axi_ar_ready, axi_ar_addr[ADDR_W], axi_ar_size[3]  AXI read address (valid/addr/size out, ready in)
- axi_r_valid, axi_r_ready, axi_r_data[DATA_W], axi_r_resp[2]  AXI read data (ready out, others in)
- axi_aw_valid, axi_aw_ready, axi_aw_addr[ADDR_W], axi_aw_size[3]  AXI write address (valid/addr/size out, ready in)
- axi_w_valid, axi_w_ready, axi_w_data[DATA_W], axi_w_strb[8]  AXI write data (valid/data/strb out, ready in)
- axi_b_valid, axi_b_ready, axi_b_resp[2]  AXI write response (ready out, others in)

Behaviour:
- Single clock clk; rst asynchronous, active-high.
- Reset state: IDLE. All outputs 0: valids, readies, resp_*, addresses, data and strb.
- req_ready = (state==IDLE).
- Accept condition: req_valid & req_uncache & req_ready.
  - On accept, register we, addr, size, wdata and strb.
  - wdata and wstrb are shifted left by addr[2:0] bytes into bus lanes.
- States:
  - IDLE: on accept, go to AR if we=0, else go to WR.
  - AR: ar_valid=1, ar_addr=addr, ar_size=size. On ar_ready, go to R.
  - R: r_ready=1. On r_valid, capture r_data>>(addr[2:0]*8), capture err=(r_resp!=0), go to RESP.
  - WR: aw_valid and w_valid both asserted in the same cycle, each deasserted independently after its own handshake. When both have completed (possibly in different cycles, or the same cycle), go to B.
  - B: b_ready=1. On b_valid, capture err=(b_resp!=0), resp_rdata=0, go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
- Timing: no new request is accepted in RESP.
- Latency with zero-wait slave: load accept→resp_valid = 3 cycles; store = 3 cycles (AW/W same cycle).
- Valids on AXI are never dropped before their handshake. Address and data are stable while valid is high.
- req_valid with req_uncache=0: ignored, state unchanged.
- rst asserted mid-transaction: immediate return to IDLE with all outputs cleared; the outstanding AXI transaction is abandoned (system-wide reset).
- Width rule: byte shift amount = addr[2:0]*8. Shifts are truncated to DATA_W; upper bits shifted out are discarded.

Optional Feature:
- Macro: UNCACHE_TIMEOUT_EN
- Defined:
  - An 8-bit-or-wider cycle counter clears on every state change and increments while in AR, R, WR or B.
  - When the counter reaches TIMEOUT_CYCLES, go to RESP with resp_err=1 and resp_rdata=0, and deassert all AXI valids/readies.
  - Debug/simulation aid only.
- Undefined: no counter; the bridge waits indefinitely.

Test Plan:
- Load, zero-wait slave: req addr=0xA000_0003, size=0, we=0; slave returns r_data=0x1122_3344_5566_7788, resp=0 → ar_addr=0xA000_0003, resp_valid at cycle 3, resp_rdata=0x0011_2233_4455, resp_err=0.
- Store with lane shift: addr=0xA000_0004, wdata=0xDEAD_BEEF, wstrb=0x0F, size=2 → w_data=0xDEAD_BEEF_0000_0000, w_strb=0xF0. b_resp=0 → one resp_valid pulse, resp_err=0.
- Split AW/W handshake: aw_ready at cycle 1, w_ready delayed to cycle 4 → aw_valid low from cycle 2, w_valid high until cycle 4, B entered only after cycle 4, one resp_valid.
- Error and filtering:
  - r_resp=2'b10 → resp_err=1.
  - A request with req_uncache=0 while IDLE → no AXI activity, req_ready stays 1.
- Back-pressure and reset: ar_ready held low for 20 cycles → ar_valid and ar_addr stable throughout. rst pulsed in cycle 10 → all outputs 0 in the same cycle, req_ready=1 after release.
- With UNCACHE_TIMEOUT_EN, TIMEOUT_CYCLES=8: slave never asserts r_valid → resp_valid with resp_err=1 eight cycles after entering R, then IDLE.

Source files
------------

// File: rtl/ysyx_2022040010_uncache_bridge.sv
// ysyx_2022040010_uncache_bridge
// Bridges one uncached (MMIO) LSU load/store at a time onto a single-beat
// AXI4 read or write transaction and returns a byte-lane-aligned result.
// Optional watchdog: define UNCACHE_TIMEOUT_EN to abort a stalled
// transaction after TIMEOUT_CYCLES cycles in any AXI-waiting state.
module ysyx_2022040010_uncache_bridge #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_uncache,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              axi_ar_valid,
  input  logic              axi_ar_ready,
  output logic [ADDR_W-1:0] axi_ar_addr,
  output logic [2:0]        axi_ar_size,
  input  logic              axi_r_valid,
  output logic              axi_r_ready,
  input  logic [DATA_W-1:0] axi_r_data,
  input  logic [1:0]        axi_r_resp,
  output logic              axi_aw_valid,
  input  logic              axi_aw_ready,
  output logic [ADDR_W-1:0] axi_aw_addr,
  output logic [2:0]        axi_aw_size,
  output logic              axi_w_valid,
  input  logic              axi_w_ready,
  output logic [DATA_W-1:0] axi_w_data,
  output logic [7:0]        axi_w_strb,
  input  logic              axi_b_valid,
  output logic              axi_b_ready,
  input  logic [1:0]        axi_b_resp
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              aw_ok, w_ok;
  logic [5:0]        req_shamt, rsp_shamt;
`ifdef UNCACHE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0]       cnt_q, cnt_d;
`endif

  // Byte offset inside the 8-byte bus word, scaled to a bit shift.
  assign req_shamt = {req_addr[2:0], 3'b000};
  assign rsp_shamt = {addr_q[2:0], 3'b000};

  // A channel counts as done once it handshook earlier or handshakes now.
  assign aw_ok = aw_done_q | axi_aw_ready;
  assign w_ok  = w_done_q  | axi_w_ready;

  // State and captured-request registers; reset clears every output source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= 3'd0;
      wdata_q   <= '0;
      wstrb_q   <= 8'd0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef UNCACHE_TIMEOUT_EN
      cnt_q     <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef UNCACHE_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Next-state logic: request capture, AXI handshakes and response capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_uncache) begin
          addr_d    = req_addr;
          size_d    = req_size;
          wdata_d   = req_wdata << req_shamt;
          wstrb_d   = req_wstrb << req_addr[2:0];
          rdata_d   = '0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_we ? S_WR : S_AR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AR: begin
        if (axi_ar_ready) begin
          state_d = S_R;
        end else begin
          state_d = S_AR;
        end
      end
      S_R: begin
        if (axi_r_valid) begin
          rdata_d = axi_r_data >> rsp_shamt;
          err_d   = (axi_r_resp != 2'b00);
          state_d = S_RESP;
        end else begin
          state_d = S_R;
        end
      end
      S_WR: begin
        aw_done_d = aw_ok;
        w_done_d  = w_ok;
        if (aw_ok && w_ok) begin
          state_d = S_B;
        end else begin
          state_d = S_WR;
        end
      end
      S_B: begin
        if (axi_b_valid) begin
          err_d   = (axi_b_resp != 2'b00);
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          state_d = S_B;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef UNCACHE_TIMEOUT_EN
    // Watchdog overrides a stalled AXI wait; any progress restarts it.
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end else if (state_q inside {S_AR, S_R, S_WR, S_B}) begin
      if ((cnt_q + 16'd1) >= TIMEOUT_LIM) begin
        state_d = S_RESP;
        err_d   = 1'b1;
        rdata_d = '0;
        cnt_d   = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
`endif
  end

  // Outputs decode directly from registered state; payloads are held flops,
  // so address/data stay stable while any valid is high.
  assign req_ready    = (state_q == S_IDLE) && !rst;
  assign resp_valid   = (state_q == S_RESP);
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;
  assign axi_ar_valid = (state_q == S_AR);
  assign axi_ar_addr  = addr_q;
  assign axi_ar_size  = size_q;
  assign axi_r_ready  = (state_q == S_R);
  assign axi_aw_valid = (state_q == S_WR) && !aw_done_q;
  assign axi_aw_addr  = addr_q;
  assign axi_aw_size  = size_q;
  assign axi_w_valid  = (state_q == S_WR) && !w_done_q;
  assign axi_w_data   = wdata_q;
  assign axi_w_strb   = wstrb_q;
  assign axi_b_ready  = (state_q == S_B);

endmodule

// File: tb/tb_ysyx_2022040010_uncache_bridge.sv
// Scoreboard bench for ysyx_2022040010_uncache_bridge: a driver issues
// requests and queues the expected response, an AXI slave model serves the
// bus side, and a monitor pops and compares on every resp_valid.
module tb_ysyx_2022040010_uncache_bridge;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata;
    logic [1:0]  resp;
  } txn_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_uncache, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic [7:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic        axi_ar_valid, axi_ar_ready;
  logic [63:0] axi_ar_addr;
  logic [2:0]  axi_ar_size;
  logic        axi_r_valid, axi_r_ready;
  logic [63:0] axi_r_data;
  logic [1:0]  axi_r_resp;
  logic        axi_aw_valid, axi_aw_ready;
  logic [63:0] axi_aw_addr;
  logic [2:0]  axi_aw_size;
  logic        axi_w_valid, axi_w_ready;
  logic [63:0] axi_w_data;
  logic [7:0]  axi_w_strb;
  logic        axi_b_valid, axi_b_ready;
  logic [1:0]  axi_b_resp;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  txn_t cur;
  logic [63:0] exp_wdata;
  logic [7:0]  exp_wstrb;
  logic zero_wait, hold_ar, r_pend, b_pend, aw_got, w_got, prev_rv;
  int   w_hold, r_dly, b_dly;

  ysyx_2022040010_uncache_bridge dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_uncache(req_uncache),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_ar_addr(axi_ar_addr), .axi_ar_size(axi_ar_size),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
    .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
    .axi_aw_addr(axi_aw_addr), .axi_aw_size(axi_aw_size),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready),
    .axi_b_resp(axi_b_resp)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_ctl"}, 64'({req_ready, resp_valid, resp_err, axi_ar_valid, axi_r_ready,
                           axi_aw_valid, axi_w_valid, axi_b_ready}), 64'd0);
    chk({nm, "_bus"}, resp_rdata | axi_ar_addr | axi_aw_addr | axi_w_data, 64'd0);
    chk({nm, "_sz"}, 64'({axi_ar_size, axi_aw_size, axi_w_strb}), 64'd0);
  endtask

  function automatic txn_t mk(input logic we, input logic [63:0] addr, input logic [2:0] size,
                              input logic [63:0] wdata, input logic [7:0] wstrb,
                              input logic [63:0] rdata, input logic [1:0] resp);
    txn_t t;
    t.we = we; t.addr = addr; t.size = size; t.wdata = wdata;
    t.wstrb = wstrb; t.rdata = rdata; t.resp = resp;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    logic [31:0] lo;
    lo = 32'hA000_0000 | ($urandom & 32'h0000_FFFF);
    return mk(1'($urandom_range(0, 1)), {32'h0, lo}, 3'($urandom_range(0, 3)),
              {$urandom, $urandom}, 8'($urandom), {$urandom, $urandom},
              ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
  endfunction

  // Issue one uncached request and queue what the core should get back.
  task automatic start_req(input txn_t t, input int lat);
    exp_t e;
    int   off;
    @(negedge clk);
    off = int'(t.addr[2:0]);
    cur = t;
    exp_wdata = t.wdata * (64'd1 << (8 * off));
    exp_wstrb = 8'((int'(t.wstrb) * (1 << off)) % 256);
    req_valid = 1'b1; req_uncache = 1'b1; req_we = t.we; req_addr = t.addr;
    req_size = t.size; req_wdata = t.wdata; req_wstrb = t.wstrb;
    e.rdata = t.we ? 64'd0 : (t.rdata >> (8 * off));
    e.err   = (t.resp != 2'b00);
    e.acc   = cyc;
    e.lat   = lat;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("resp_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // AXI slave model: drives readies/responses for the interval before each
  // rising edge and checks the request side at each handshake.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      axi_ar_ready = 1'b0; axi_r_valid = 1'b0; axi_aw_ready = 1'b0;
      axi_w_ready = 1'b0; axi_b_valid = 1'b0;
      r_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
    end else begin
      if (r_pend && r_dly > 0) begin
        r_dly--; axi_r_valid = 1'b0;
      end else if (r_pend) begin
        axi_r_valid = 1'b1; axi_r_data = cur.rdata; axi_r_resp = cur.resp;
      end else begin
        axi_r_valid = 1'b0;
      end
      if (axi_r_valid && axi_r_ready) r_pend = 1'b0;
      axi_ar_ready = hold_ar ? 1'b0 : (zero_wait ? 1'b1 : 1'($urandom_range(0, 1)));
      if (axi_ar_valid && axi_ar_ready) begin
        chk("ar_addr", axi_ar_addr, cur.addr);
        chk("ar_size", 64'(axi_ar_size), 64'(cur.size));
        r_pend = 1'b1;
        r_dly = zero_wait ? 0 : $urandom_range(0, 3);
      end
      if (b_pend && b_dly > 0) begin
        b_dly--; axi_b_valid = 1'b0;
      end else if (b_pend) begin
        axi_b_valid = 1'b1; axi_b_resp = cur.resp;
      end else begin
        axi_b_valid = 1'b0;
      end
      if (axi_b_valid && axi_b_ready) b_pend = 1'b0;
      axi_aw_ready = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
      if (w_hold > 0 && axi_w_valid) begin
        axi_w_ready = 1'b0; w_hold--;
      end else begin
        axi_w_ready = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (aw_got) chk("aw_valid_after_hs", 64'(axi_aw_valid), 64'd0);
      if (w_got) chk("w_valid_after_hs", 64'(axi_w_valid), 64'd0);
      if ((aw_got || axi_aw_valid) && !w_got) chk("w_valid_held", 64'(axi_w_valid), 64'd1);
      if (axi_aw_valid && axi_aw_ready) begin
        chk("aw_addr", axi_aw_addr, cur.addr);
        chk("aw_size", 64'(axi_aw_size), 64'(cur.size));
        aw_got = 1'b1;
      end
      if (axi_w_valid && axi_w_ready) begin
        chk("w_data", axi_w_data, exp_wdata);
        chk("w_strb", 64'(axi_w_strb), 64'(exp_wstrb));
        w_got = 1'b1;
      end
      if (aw_got && w_got) begin
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
        b_dly = zero_wait ? 0 : $urandom_range(0, 3);
      end
    end
  end

  // Monitor: every response pulse is matched against the scoreboard head.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && resp_valid) begin
      chk("resp_single_pulse", 64'(prev_rv), 64'd0);
      chk("req_ready_in_resp", 64'(req_ready), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 64'(resp_err), 64'(e.err));
        if (e.lat >= 0) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
    prev_rv = resp_valid && !rst;
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_uncache = 1'b0; req_we = 1'b0;
    req_addr = 64'd0; req_size = 3'd0; req_wdata = 64'd0; req_wstrb = 8'd0;
    axi_ar_ready = 1'b0; axi_r_valid = 1'b0; axi_r_data = 64'd0; axi_r_resp = 2'b00;
    axi_aw_ready = 1'b0; axi_w_ready = 1'b0; axi_b_valid = 1'b0; axi_b_resp = 2'b00;
    zero_wait = 1'b1; hold_ar = 1'b0; w_hold = 0; prev_rv = 1'b0;
    r_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; r_dly = 0; b_dly = 0;
    cur = mk(1'b0, 64'd0, 3'd0, 64'd0, 8'd0, 64'd0, 2'b00);
    exp_wdata = 64'd0; exp_wstrb = 8'd0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    #1 chk("ready_after_reset", 64'(req_ready), 64'd1);

    // Zero-wait load with byte offset 3.
    start_req(mk(1'b0, 64'hA000_0003, 3'd0, 64'd0, 8'd0, 64'h1122_3344_5566_7788, 2'b00), 3);
    wait_resp();
    // Zero-wait store with lane shift into the upper word half.
    start_req(mk(1'b1, 64'hA000_0004, 3'd2, 64'hDEAD_BEEF, 8'h0F, 64'd0, 2'b00), 3);
    wait_resp();
    // Load with SLVERR.
    start_req(mk(1'b0, 64'hA000_0008, 3'd3, 64'd0, 8'd0, 64'h0BAD_F00D_1234_5678, 2'b10), 3);
    wait_resp();
    // Split AW/W handshake: W accepted three cycles after AW.
    w_hold = 3;
    start_req(mk(1'b1, 64'hA000_0101, 3'd0, 64'h0000_00A5, 8'h01, 64'd0, 2'b00), 6);
    wait_resp();
    w_hold = 0;

    // Cached request must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_uncache = 1'b0; req_we = 1'b0; req_addr = 64'h8000_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("filter_ready", 64'(req_ready), 64'd1);
      chk("filter_axi", 64'({axi_ar_valid, axi_aw_valid, axi_w_valid}), 64'd0);
    end
    req_valid = 1'b0;

    // AR back-pressure for 20 cycles: valid and address must hold.
    hold_ar = 1'b1;
    start_req(mk(1'b0, 64'hA000_0206, 3'd1, 64'd0, 8'd0, 64'hCAFE_0000_0000_BEEF, 2'b00), -1);
    for (int i = 0; i < 20; i++) begin
      chk("bp_ar_valid", 64'(axi_ar_valid), 64'd1);
      chk("bp_ar_addr", axi_ar_addr, 64'hA000_0206);
      @(negedge clk);
    end
    hold_ar = 1'b0;
    wait_resp();

    // Reset in the middle of a stalled load.
    hold_ar = 1'b1;
    start_req(mk(1'b0, 64'hA000_0310, 3'd3, 64'd0, 8'd0, 64'h1, 2'b00), -1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1 check_all_zero("mid_reset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0; hold_ar = 1'b0;
    r_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
    #1 chk("ready_after_mid_reset", 64'(req_ready), 64'd1);

    // Randomized traffic with a stalling slave.
    zero_wait = 1'b0;
    for (int i = 0; i < 40; i++) begin
      start_req(rand_txn(), -1);
      wait_resp();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
